// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment scan driver: active-low
// segment patterns {g,f,e,d,c,b,a}, digit count and FSM state encoding.
package seg_pkg;

  localparam int unsigned NumDigits = 6;

  typedef logic [5:0] digit_t;
  typedef logic [6:0] seg_t;

  localparam seg_t Seg0     = 7'h40;
  localparam seg_t Seg1     = 7'h79;
  localparam seg_t Seg2     = 7'h24;
  localparam seg_t Seg3     = 7'h30;
  localparam seg_t Seg4     = 7'h19;
  localparam seg_t Seg5     = 7'h12;
  localparam seg_t Seg6     = 7'h02;
  localparam seg_t Seg7     = 7'h78;
  localparam seg_t Seg8     = 7'h00;
  localparam seg_t Seg9     = 7'h10;
  localparam seg_t SegDash  = 7'h3F;
  localparam seg_t SegBlank = 7'h7F;

  localparam logic [0:0] StGap = 1'b0;
  localparam logic [0:0] StOn  = 1'b1;

endpackage

// File: rtl/seg_scan_driver_if.sv
// Digit inputs from the decimal counter plus the multiplexed display outputs.
interface seg_scan_driver_if;

  logic       hold;
  logic [5:0] d1;
  logic [5:0] d2;
  logic [5:0] d3;
  logic [5:0] d4;
  logic [5:0] d5;
  logic [5:0] d6;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_done;

  modport master (
    output hold, d1, d2, d3, d4, d5, d6,
    input  seg, an, frame_done
  );

  modport slave (
    input  hold, d1, d2, d3, d4, d5, d6,
    output seg, an, frame_done
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational digit-to-segment decoder; values above 9 show a dash.
module seg7_decode
  import seg_pkg::*;
(
  input  digit_t value,
  input  logic   blank,
  output seg_t   pattern
);

  always_comb begin
    pattern = SegDash;
    if (blank) begin
      pattern = SegBlank;
    end else begin
      unique case (value)
        6'd0:    pattern = Seg0;
        6'd1:    pattern = Seg1;
        6'd2:    pattern = Seg2;
        6'd3:    pattern = Seg3;
        6'd4:    pattern = Seg4;
        6'd5:    pattern = Seg5;
        6'd6:    pattern = Seg6;
        6'd7:    pattern = Seg7;
        6'd8:    pattern = Seg8;
        6'd9:    pattern = Seg9;
        default: pattern = SegDash;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed display scanner: each digit is lit for SCAN_DIV cycles,
// separated by GAP all-off cycles; the digits are snapshotted once per frame.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned GAP      = 1000,
  parameter bit          BLANK_LZ = 1'b1
) (
  input logic               clk,
  input logic               rst,
  seg_scan_driver_if.slave  bus
);

  localparam int unsigned CntMax = (SCAN_DIV > GAP) ? SCAN_DIV : GAP;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] OnLast  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP - 1);
  localparam logic [2:0]      IdxLast = 3'(NumDigits - 1);

  logic [0:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  digit_t          snap_q [NumDigits];
  digit_t          snap_d [NumDigits];
  digit_t          din    [NumDigits];
  seg_t            seg_q, seg_d, dec_pattern;
  logic [5:0]      an_q, an_d;
  logic            fd_q, fd_d;
  logic            enter_on, leave_on, lz_blank, dec_blank;
  digit_t          dec_value;

  assign din = '{bus.d1, bus.d2, bus.d3, bus.d4, bus.d5, bus.d6};

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + 1'b1;
    snap_d   = snap_q;
    enter_on = 1'b0;
    leave_on = 1'b0;
    if (state_q == StGap) begin
      if (cnt_q == GapLast) begin
        state_d  = StOn;
        cnt_d    = '0;
        idx_d    = (idx_q == IdxLast) ? 3'd0 : idx_q + 3'd1;
        enter_on = 1'b1;
      end
    end else if (cnt_q == OnLast) begin
      state_d  = StGap;
      cnt_d    = '0;
      leave_on = 1'b1;
    end
    // Snapshot on the same edge the first digit lights, so decode sees it.
    if (enter_on && idx_d == 3'd0 && !bus.hold) begin
      snap_d = din;
    end
    fd_d = enter_on && (idx_d == 3'd0);
  end

  always_comb begin
    lz_blank = 1'b1;
    for (int k = 0; k < NumDigits; k++) begin
      if (3'(k) <= idx_d && snap_d[k] != '0) begin
        lz_blank = 1'b0;
      end
    end
    dec_blank = BLANK_LZ && (idx_d != IdxLast) && lz_blank;
    dec_value = snap_d[idx_d];
  end

  seg7_decode u_decode (
    .value   (dec_value),
    .blank   (dec_blank),
    .pattern (dec_pattern)
  );

  always_comb begin
    an_d  = an_q;
    seg_d = seg_q;
    if (enter_on) begin
      an_d  = ~(6'b000001 << idx_d);
      seg_d = dec_pattern;
    end else if (leave_on) begin
      an_d  = '1;
      seg_d = SegBlank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StGap;
      idx_q   <= IdxLast;
      cnt_q   <= '0;
      snap_q  <= '{default: '0};
      an_q    <= '1;
      seg_q   <= SegBlank;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (SCAN_DIV=4, GAP=2) with leading-zero blanking on and off.
module tb_seg_scan_driver;

  localparam int ScanDiv = 4;
  localparam int GapCyc  = 2;
  localparam int Slot    = ScanDiv + GapCyc;
  localparam int Frame   = 6 * Slot;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hold = 1'b0;
  logic [5:0] din [6] = '{default: 6'd0};

  always #5 clk = ~clk;

  seg_scan_driver_if bus_b ();
  seg_scan_driver_if bus_n ();

  assign bus_b.hold = hold;
  assign bus_n.hold = hold;
  assign bus_b.d1 = din[0];
  assign bus_b.d2 = din[1];
  assign bus_b.d3 = din[2];
  assign bus_b.d4 = din[3];
  assign bus_b.d5 = din[4];
  assign bus_b.d6 = din[5];
  assign bus_n.d1 = din[0];
  assign bus_n.d2 = din[1];
  assign bus_n.d3 = din[2];
  assign bus_n.d4 = din[3];
  assign bus_n.d5 = din[4];
  assign bus_n.d6 = din[5];

  seg_scan_driver #(.SCAN_DIV(ScanDiv), .GAP(GapCyc), .BLANK_LZ(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  seg_scan_driver #(.SCAN_DIV(ScanDiv), .GAP(GapCyc), .BLANK_LZ(1'b0)) dut_n (
    .clk (clk),
    .rst (rst),
    .bus (bus_n)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: cycles since the last reset edge plus the frame snapshot.
  int         n = 0;
  bit         started = 1'b0;
  logic [5:0] snap [6] = '{default: 6'd0};
  logic [6:0] pat [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at n=%0d: got %h want %h", name, n, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(int pos, bit blz);
    bit allz = 1'b1;
    for (int k = 0; k <= pos; k++) if (snap[k] != 6'd0) allz = 1'b0;
    if (blz && pos < 5 && allz) return 7'h7F;
    if (snap[pos] > 6'd9) return 7'h3F;
    return pat[snap[pos]];
  endfunction

  task automatic step();
    int p;
    @(posedge clk);
    if (rst) begin
      n = 0;
      snap = '{default: 6'd0};
      started = 1'b1;
    end else begin
      n++;
      if (n % Frame == GapCyc && !hold) snap = din;
    end
    #1;
    if (started) begin
      p = n % Frame;
      if (p % Slot >= GapCyc) begin
        chk("model_an_b", 32'(bus_b.an), 32'(~(6'b000001 << (p / Slot)) & 6'h3F));
        chk("model_an_n", 32'(bus_n.an), 32'(~(6'b000001 << (p / Slot)) & 6'h3F));
        chk("model_seg_b", 32'(bus_b.seg), 32'(exp_seg(p / Slot, 1'b1)));
        chk("model_seg_n", 32'(bus_n.seg), 32'(exp_seg(p / Slot, 1'b0)));
      end else begin
        chk("model_an_off", 32'(bus_b.an), 32'h3F);
        chk("model_seg_off", 32'(bus_b.seg), 32'h7F);
      end
      chk("model_fd", 32'(bus_b.frame_done), 32'(p == GapCyc));
    end
  endtask

  task automatic run_to(int slot, int q);
    int guard = 0;
    do begin
      step();
      guard++;
    end while (!(((n % Frame) / Slot) == slot && ((n % Frame) % Slot) == q) && guard < 200);
    if (guard >= 200) begin
      vecs++;
      errs++;
      $display("FAIL run_to_bound: got %0d cycles want <200", guard);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [5:0] d  [6];
    logic [6:0] e1 [6];
    logic [6:0] e0 [6];
  } vec_t;

  vec_t tbl [5];

  initial begin
    int cnt;
    tbl[0] = '{d: '{0, 0, 0, 1, 2, 3},
               e1: '{7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h30},
               e0: '{7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h30}};
    tbl[1] = '{d: '{0, 0, 0, 0, 0, 0},
               e1: '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40},
               e0: '{7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
    tbl[2] = '{d: '{0, 0, 12, 0, 0, 0},
               e1: '{7'h7F, 7'h7F, 7'h3F, 7'h40, 7'h40, 7'h40},
               e0: '{7'h40, 7'h40, 7'h3F, 7'h40, 7'h40, 7'h40}};
    tbl[3] = '{d: '{9, 8, 7, 6, 5, 4},
               e1: '{7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19},
               e0: '{7'h10, 7'h00, 7'h78, 7'h02, 7'h12, 7'h19}};
    tbl[4] = '{d: '{0, 63, 0, 0, 10, 0},
               e1: '{7'h7F, 7'h3F, 7'h40, 7'h40, 7'h3F, 7'h40},
               e0: '{7'h40, 7'h3F, 7'h40, 7'h40, 7'h3F, 7'h40}};

    // Reset state
    rst = 1'b1;
    step();
    chk("rst_an", 32'(bus_b.an), 32'h3F);
    chk("rst_seg", 32'(bus_b.seg), 32'h7F);
    chk("rst_fd", 32'(bus_b.frame_done), 32'h0);

    // Table: one full frame per record, seg per lit position
    for (int r = 0; r < 5; r++) begin
      din = tbl[r].d;
      pulse_reset();
      for (int i = 1; i <= Frame; i++) begin
        step();
        if ((n % Frame) % Slot >= GapCyc) begin
          chk("tbl_seg_blz1", 32'(bus_b.seg), 32'(tbl[r].e1[(n % Frame) / Slot]));
          chk("tbl_seg_blz0", 32'(bus_n.seg), 32'(tbl[r].e0[(n % Frame) / Slot]));
        end
      end
    end

    // Frame period measured from the DUT's own pulses
    run_to(0, GapCyc);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (bus_b.frame_done !== 1'b1 && cnt < 100);
    chk("frame_period", 32'(cnt), 32'(Frame));

    // Mid-frame change with hold=0, then hold=1 freezing the snapshot
    din = '{0, 0, 0, 0, 0, 5};
    hold = 1'b0;
    pulse_reset();
    run_to(0, 3);
    din[5] = 6'd7;
    run_to(5, 3);
    chk("midframe_old", 32'(bus_b.seg), 32'h12);
    run_to(5, 3);
    chk("nextframe_new", 32'(bus_b.seg), 32'h78);
    din[5] = 6'd5;
    run_to(5, 3);
    chk("back_to_5", 32'(bus_b.seg), 32'h12);
    hold = 1'b1;
    din[5] = 6'd7;
    run_to(5, 3);
    chk("hold_frame1", 32'(bus_b.seg), 32'h12);
    run_to(5, 3);
    chk("hold_frame2", 32'(bus_b.seg), 32'h12);
    hold = 1'b0;

    // Reset while position 3 is lit
    din = '{1, 2, 3, 4, 5, 6};
    run_to(2, 3);
    chk("pos3_lit", 32'(bus_b.an), 32'h3B);
    rst = 1'b1;
    step();
    chk("midrst_an", 32'(bus_b.an), 32'h3F);
    chk("midrst_seg", 32'(bus_b.seg), 32'h7F);
    rst = 1'b0;
    step();
    chk("postrst_gap", 32'(bus_b.an), 32'h3F);
    step();
    chk("postrst_on_an", 32'(bus_b.an), 32'h3E);
    chk("postrst_on_fd", 32'(bus_b.frame_done), 32'h1);

    // Randomized digits, hold and occasional reset against the model
    for (int i = 0; i < 25 * Frame; i++) begin
      step();
      rst = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0:       din[$urandom_range(0, 5)] = 6'd0;
          1:       din[$urandom_range(0, 5)] = 6'($urandom_range(10, 63));
          default: din[$urandom_range(0, 5)] = 6'($urandom_range(0, 9));
        endcase
      end
      if ($urandom_range(0, 3) == 0 && $urandom_range(0, 5) == 0) din = '{default: 6'd0};
      if ($urandom_range(0, 29) == 0) hold = ~hold;
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter: SCAN_DIV, default 50000, clk cycles each digit is lit (min 2).
REQ-002 Parameter: GAP, default 1000, all-digits-off cycles between digits for anti-ghosting (min 1).
REQ-003 Parameter: BLANK_LZ, default 1, enables leading-zero blanking.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 hold  input  1  when 1, freezes the displayed value (frame snapshot skipped).
REQ-007 d1..d6  input  6 each  digit values from the decimal counter; d1 is most significant, d6 least.
REQ-008 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  6  digit enables, active-low; an[0] drives d1 position, an[5] drives d6.
REQ-010 frame_done  output  1  one-cycle pulse at the start of each display frame.

Function
REQ-011 The block SHALL run a two-state FSM, GAP and ON, with a digit index idx in 0..5 and a cycle counter.
REQ-012 In GAP the block SHALL hold an=6'b111111 and seg=7'h7F for exactly GAP cycles.
REQ-013 In ON the block SHALL drive an[idx]=0, all other an bits 1, for exactly SCAN_DIV cycles, then enter GAP.
REQ-014 On GAP expiry the block SHALL enter ON with idx advanced by one, wrapping 5 -> 0.
REQ-015 On entry to ON with idx=0, the block SHALL latch d1..d6 into internal snapshot registers unless hold=1 on that edge, and SHALL assert frame_done for exactly that one cycle.
REQ-016 seg in ON SHALL be the decode of snapshot digit idx: 0=40,1=79,2=24,3=30,4=19,5=12,6=02,7=78,8=00,9=10 (hex).
REQ-017 A snapshot value greater than 9 (10..63) SHALL display dash 7'h3F; no other values are decoded.
REQ-018 With BLANK_LZ=1, position k (1..5) SHALL display 7'h7F when snapshot digits 1..k are all zero; position 6 SHALL never be blanked; a value >9 counts as nonzero.
REQ-019 seg and an SHALL be registered outputs that change only on a state or idx transition edge; no glitches within a phase.
REQ-020 Frame period SHALL be exactly 6*(SCAN_DIV+GAP) cycles; input changes mid-frame SHALL NOT affect the current frame.
REQ-021 hold changing mid-frame SHALL have no effect until the next idx=0 entry.

Reset
REQ-022 While rst=1 on an edge, the block SHALL set state=GAP, idx=5, counter=0, snapshot=0, an=6'b111111, seg=7'h7F, frame_done=0.
REQ-023 After reset release, the first ON phase SHALL start at idx=0 after exactly GAP cycles, with frame_done=1 and a snapshot taken.
REQ-024 rst asserted mid-frame SHALL abort the frame on that edge with no partial digit remaining lit.

Structure
REQ-025 A shared package seg_pkg SHALL hold the seven-segment pattern constants (digits, DASH, BLANK), the digit count 6, and the FSM state encoding.
REQ-026 Digit-to-segment decoding SHALL be a separate combinational sub-module seg7_decode (6-bit value + blank flag in, 7-bit pattern out), instantiated once.

Verification (SCAN_DIV=4, GAP=2)
REQ-027 Reset release with d1..d6=0,0,0,1,2,3 -> an=111111 for 2 cycles, then frame_done=1, an=111110, seg=7F; positions 1-3 blank, position 4 seg=79, position 5 seg=24, position 6 seg=30.
REQ-028 Free run -> frame_done pulses every 36 cycles; each an bit low exactly 4 consecutive cycles per frame, with 2 all-off cycles before each digit.
REQ-029 d1..d6=0,0,0,0,0,0 -> positions 1-5 seg=7F, position 6 seg=40; with BLANK_LZ=0, all six positions seg=40.
REQ-030 d3=12, others 0 -> positions 1-2 blank, position 3 seg=3F, positions 4-6 seg=40.
REQ-031 Change d6 from 5 to 7 mid-frame with hold=0 -> display shows 12 until the next frame_done, 78 afterwards; repeat with hold=1 -> 12 persists across frames.
REQ-032 Assert rst for one cycle while position 3 is lit -> next cycle an=111111, seg=7F; idx=0 ON begins 2 cycles after release.
